// File: rtl/nn_parameters.sv
// Network-wide parameters shared by the dense layers and the classification stage.
package nn_parameters;

   localparam int OUT_SIZE_4 = 3;
   localparam int DATA_W     = 32;

   // Index width, never narrower than one bit so a single-class build still elaborates.
   function automatic int idx_width(input int n);
      idx_width = (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/final_layer_argmax_comb.sv
// Combinational argmax over signed scores; ties keep the lowest index.
import nn_parameters::*;

module argmax_comb #(
   parameter int OUT_SIZE_4 = nn_parameters::OUT_SIZE_4,
   parameter int DATA_W     = nn_parameters::DATA_W,
   parameter int IDX_W      = idx_width(OUT_SIZE_4)
) (
   input  logic signed [DATA_W-1:0] input_vector [OUT_SIZE_4-1:0],
   output logic        [IDX_W-1:0]  max_idx
);

   logic signed [DATA_W-1:0] best_val_s;
   logic        [IDX_W-1:0]  best_idx_s;

   // Linear scan; strict greater-than means equal later scores never displace an earlier one.
   always_comb begin
      best_val_s = input_vector[0];
      best_idx_s = {IDX_W{1'b0}};
      for (int i = 1; i < OUT_SIZE_4; i++) begin
         if (input_vector[i] > best_val_s) begin
            best_val_s = input_vector[i];
            best_idx_s = IDX_W'(i);
         end else begin
            best_val_s = best_val_s;
            best_idx_s = best_idx_s;
         end
      end
   end

   assign max_idx = best_idx_s;

endmodule

// File: rtl/final_layer_argmax.sv
// Classification output stage: registers the index of the highest final-layer score.
import nn_parameters::*;

module final_layer_argmax #(
   parameter int OUT_SIZE_4 = nn_parameters::OUT_SIZE_4,
   parameter int DATA_W     = nn_parameters::DATA_W,
   parameter int IDX_W      = idx_width(OUT_SIZE_4)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] input_vector [OUT_SIZE_4-1:0],
   output logic        [IDX_W-1:0]  output_value
);

   logic [IDX_W-1:0] max_idx_s;
   logic [IDX_W-1:0] value_r;

   argmax_comb #(
      .OUT_SIZE_4 (OUT_SIZE_4),
      .DATA_W     (DATA_W),
      .IDX_W      (IDX_W)
   ) u_argmax (
      .input_vector (input_vector),
      .max_idx      (max_idx_s)
   );

   // Decision register; reset clears it immediately, independent of the clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_r <= {IDX_W{1'b0}};
      end else begin
         value_r <= max_idx_s;
      end
   end

   assign output_value = value_r;

endmodule

// File: tb/tb_final_layer_argmax.sv
// Directed self-checking bench for final_layer_argmax (3 classes, 32-bit scores).
module tb_final_layer_argmax;

   logic                clk;
   logic                rst;
   logic signed [31:0]  vec [2:0];
   logic        [1:0]   output_value;

   int checks;
   int errors;

   final_layer_argmax dut (
      .clk          (clk),
      .rst          (rst),
      .input_vector (vec),
      .output_value (output_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [1:0] expected);
      checks++;
      assert (output_value === expected) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, output_value, expected);
      end
   endtask

   // Apply a vector just after an edge, then check the result just after the next edge.
   task automatic step(input string tag, input logic signed [31:0] a0,
                       input logic signed [31:0] a1, input logic signed [31:0] a2,
                       input logic [1:0] expected);
      vec[0] = a0;
      vec[1] = a1;
      vec[2] = a2;
      @(posedge clk);
      #1;
      check(tag, expected);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      vec[0] = 32'sd0;
      vec[1] = 32'sd9;
      vec[2] = 32'sd0;
      #1;
      check("reset_t0", 2'd0);

      for (int i = 0; i < 100; i++) begin
         vec[0] = $signed($urandom);
         vec[1] = $signed($urandom);
         vec[2] = $signed($urandom);
         @(posedge clk);
         #1;
         check("reset_hold", 2'd0);
      end
      rst = 1'b0;

      step("distinct_pos",   32'sd2000000, 32'sd300000, 32'sd500, 2'd0);
      step("distinct_stable", 32'sd2000000, 32'sd300000, 32'sd500, 2'd0);
      step("max_top",        32'sd1, 32'sd2, 32'sh7FFF_FFFF, 2'd2);
      step("max_mid",        32'sd5, 32'sd10, 32'sd5, 2'd1);
      step("neg_most",       -32'sd5, -32'sd1, 32'sh8000_0000, 2'd1);
      step("signed_pick",    -32'sd1, -32'sd2, 32'sd1, 2'd2);
      step("tie_all",        32'sd7, 32'sd7, 32'sd7, 2'd0);
      step("tie_upper",      32'sd3, 32'sd9, 32'sd9, 2'd1);
      step("tie_low_pair",   32'sd4, 32'sd4, -32'sd4, 2'd0);

      // Back-to-back: each result must track the vector applied one edge earlier.
      step("b2b_0", 32'sd0, 32'sd0, 32'sd1, 2'd2);
      step("b2b_1", 32'sd0, 32'sd1, 32'sd0, 2'd1);
      step("b2b_2", 32'sd1, 32'sd0, 32'sd0, 2'd0);
      step("b2b_3", 32'sh8000_0000, 32'sh7FFF_FFFF, 32'sd0, 2'd1);
      step("b2b_4", 32'sd100, -32'sd100, 32'sd101, 2'd2);

      // Input change between edges must not leak through before the next edge.
      vec[0] = 32'sd50;
      vec[1] = 32'sd0;
      vec[2] = 32'sd0;
      #2;
      check("mid_cycle_hold", 2'd2);
      @(posedge clk);
      #1;
      check("mid_cycle_update", 2'd0);

      // Async reset between edges clears the output at once.
      step("pre_reset", 32'sd0, 32'sd0, 32'sd3, 2'd2);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", 2'd0);
      @(posedge clk);
      #1;
      check("async_reset_held", 2'd0);
      #1;
      rst = 1'b0;
      #1;
      check("release_no_update", 2'd0);
      @(posedge clk);
      #1;
      check("first_after_release", 2'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/final_layer_argmax.md
# final_layer_argmax

Classification output stage of the speech-recognition network. It takes the signed scores of the last fully connected layer and registers the index of the highest score as the recognised class. It sits after the final dense layer and drives the class decision to the top level. This is a purely streaming block: it has no handshake and resamples its input every clock.

## Interface
- `OUT_SIZE_4`, default 3: number of classes (score vector length); taken from `nn_parameters`.
- `DATA_W`, default 32: width of each signed score.
- `IDX_W`, default `$clog2(OUT_SIZE_4)` (2 for 3 classes): width of the class index.
- `clk`  in  1: single clock; every output register updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `input_vector`  in  `[DATA_W-1:0]` signed × `OUT_SIZE_4` (unpacked array `[OUT_SIZE_4-1:0]`): class scores, two's complement.
- `output_value`  out  `IDX_W`: index of the maximum score, registered.

## Operation
- Each cycle, compute argmax over `input_vector[0..OUT_SIZE_4-1]` using a signed comparison on the full `DATA_W` bits. No truncation or saturation is applied.
- Ties resolve to the lowest index. A later element replaces the running maximum only when it is strictly greater.
- The argmax is a combinational linear scan, or a balanced compare tree that keeps the lowest-index tie rule. Its result is captured into `output_value` on the next rising clock edge.
- Negative scores are valid; all-negative vectors still yield the index of the largest value.
- When `OUT_SIZE_4` is not a power of two, index codes `>= OUT_SIZE_4` are never produced.
- The block holds no other state. The output depends only on the input sampled at the most recent edge.

## Timing
- Latency is 1 clock: the input present before rising edge k appears on `output_value` after edge k.
- Throughput is one decision per cycle. The input may change every cycle.
- Reset: while `rst`=1, `output_value`=0, applied immediately, independent of `clk`.
- After `rst` deasserts, the first update occurs on the next rising edge.
- Reset asserted mid-stream forces 0 at once. The prior value is not retained.
- Input changes between edges do not affect `output_value` until the next edge.

## Structure
- Package `nn_parameters` owns `OUT_SIZE_4` and the score data width shared with the preceding layers.
- A combinational sub-module `argmax_comb` (inputs: vector; output: index) is natural. The top level adds only the reset register.
- Single always_ff with asynchronous reset: sensitivity on `posedge clk or posedge rst`.

## Test plan
- Reset: hold `rst`=1 for 100 cycles with arbitrary inputs, then release → `output_value`=0 throughout the reset.
- Distinct positive scores: `input_vector[2]`=500, `[1]`=300000, `[0]`=2000000 → `output_value`=0 one cycle later and stable thereafter.
- Max at the top index: `[0]`=1, `[1]`=2, `[2]`=0x7FFFFFFF → 2. Then max at the middle, `[1]`=10 and others 5 → 1 on the following cycle.
- Signed handling: `[0]`=-5, `[1]`=-1, `[2]`=0x80000000 (most negative) → 1. Also `[0]`=-1, `[2]`=+1 → 2, not an unsigned pick.
- Ties: all three equal to 7 → 0. `[1]`=`[2]`=9, `[0]`=3 → 1.
- Back-to-back changes and async reset: change the vector every cycle and check that each result lags the input by exactly 1 cycle. Assert `rst` between clock edges → `output_value` goes to 0 before the next edge.
